// File: rtl/md_scheduler.sv
// md_scheduler: sequences the shared multiply/divide unit next to the
// execute stage and owns the architectural HI/LO registers. A multi-cycle
// op stalls E while it runs, and its result is committed to HI/LO only when
// the op leaves E, so a flushed op leaves HI/LO untouched.
module md_scheduler #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  md_op_e,
    input  logic [31:0] srca_e,
    input  logic [31:0] srcb_e,
    input  logic        stall_in,
    input  logic        flush,
    output logic        stall_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement negation when the flag is set.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        if (neg) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

    state_t      state_r, state_s;
    logic [4:0]  cnt_r;
    logic [31:0] opa_r, opb_r;
    logic [31:0] divs_r, quo_r, rem_r;
    logic [31:0] res_hi_r, res_lo_r;
    logic        is_div_r, q_neg_r, r_neg_r;
    logic [63:0] prod_chain_r [MUL_CYCLES];

    logic        start_s, start_div_s, start_signed_s;
    logic [63:0] mul_a_s, mul_b_s, prod_s;
    logic [32:0] shift_s, diff_s;
    logic [31:0] quo_n_s, rem_n_s, div_hi_s, div_lo_s;

    // Decode the op in E and form the extended multiplier operands.
    always_comb begin
        start_s        = (md_op_e >= OP_MULT) && (md_op_e <= OP_DIVU) && !flush;
        start_div_s    = (md_op_e == OP_DIV) || (md_op_e == OP_DIVU);
        start_signed_s = (md_op_e == OP_MULT) || (md_op_e == OP_DIV);
        mul_a_s        = {{32{start_signed_s & srca_e[31]}}, srca_e};
        mul_b_s        = {{32{start_signed_s & srcb_e[31]}}, srcb_e};
        prod_s         = mul_a_s * mul_b_s;
    end

    // One restoring-division step, plus sign fix and divide-by-zero result.
    always_comb begin
        shift_s = {rem_r, quo_r[31]};
        diff_s  = shift_s - {1'b0, divs_r};
        if (!diff_s[32]) begin
            rem_n_s = diff_s[31:0];
            quo_n_s = {quo_r[30:0], 1'b1};
        end else begin
            rem_n_s = shift_s[31:0];
            quo_n_s = {quo_r[30:0], 1'b0};
        end
        if (opb_r == 32'd0) begin
            div_lo_s = 32'hFFFF_FFFF;
            div_hi_s = opa_r;
        end else begin
            div_lo_s = neg_if(quo_n_s, q_neg_r);
            div_hi_s = neg_if(rem_n_s, r_neg_r);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: flush always returns to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == 5'd0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (flush || !stall_in) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: stall never looks at stall_in, so no combinational loop.
    always_comb begin
        stall_md = 1'b0;
        busy     = (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: stall_md = start_s;
            ST_BUSY: stall_md = 1'b1;
            ST_DONE: stall_md = 1'b0;
            default: stall_md = 1'b0;
        endcase
    end

    // Product pipeline: stage 0 captures the product of the E operands.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < MUL_CYCLES; i++) begin
                prod_chain_r[i] <= 64'd0;
            end
        end else begin
            prod_chain_r[0] <= prod_s;
            for (int i = 1; i < MUL_CYCLES; i++) begin
                prod_chain_r[i] <= prod_chain_r[i-1];
            end
        end
    end

    // Operand latch, iteration counter, divider state and result capture.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r    <= 5'd0;
            opa_r    <= 32'd0;
            opb_r    <= 32'd0;
            divs_r   <= 32'd0;
            quo_r    <= 32'd0;
            rem_r    <= 32'd0;
            res_hi_r <= 32'd0;
            res_lo_r <= 32'd0;
            is_div_r <= 1'b0;
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (state_r == ST_IDLE && start_s) begin
            opa_r    <= srca_e;
            opb_r    <= srcb_e;
            quo_r    <= neg_if(srca_e, start_signed_s & srca_e[31]);
            divs_r   <= neg_if(srcb_e, start_signed_s & srcb_e[31]);
            rem_r    <= 32'd0;
            is_div_r <= start_div_s;
            q_neg_r  <= start_signed_s & (srca_e[31] ^ srcb_e[31]);
            r_neg_r  <= start_signed_s & srca_e[31];
            cnt_r    <= start_div_s ? 5'd31 : 5'(MUL_CYCLES - 1);
        end else if (state_r == ST_BUSY) begin
            cnt_r <= cnt_r - 5'd1;
            quo_r <= quo_n_s;
            rem_r <= rem_n_s;
            if (cnt_r == 5'd0) begin
                if (is_div_r) begin
                    res_hi_r <= div_hi_s;
                    res_lo_r <= div_lo_s;
                end else begin
                    res_hi_r <= prod_chain_r[MUL_CYCLES-1][63:32];
                    res_lo_r <= prod_chain_r[MUL_CYCLES-1][31:0];
                end
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Architectural HI/LO: result commit from DONE, MTHI/MTLO from IDLE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (state_r == ST_DONE && !stall_in && !flush) begin
            hi <= res_hi_r;
            lo <= res_lo_r;
        end else if (state_r == ST_IDLE && !stall_in && !flush) begin
            case (md_op_e)
                OP_MTHI: hi <= srca_e;
                OP_MTLO: lo <= srca_e;
                default: hi <= hi;
            endcase
        end else begin
            hi <= hi;
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Scoreboard bench for md_scheduler: expected HI/LO pushed when an op is
// issued, popped and compared when the op leaves E.
module tb_md_scheduler;

    localparam int MC = 4;

    logic        clk;
    logic        resetn;
    logic [2:0]  md_op_e;
    logic [31:0] srca_e, srcb_e;
    logic        stall_in, flush;
    logic        stall_md, busy;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    md_scheduler #(.MUL_CYCLES(MC)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .md_op_e  (md_op_e),
        .srca_e   (srca_e),
        .srcb_e   (srcb_e),
        .stall_in (stall_in),
        .flush    (flush),
        .stall_md (stall_md),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic built on the simulator's own operators.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.hi = 32'd0;
        e.lo = 32'd0;
        case (op)
            3'd1: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd3: begin
                if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
                else begin q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0]; end
            end
            3'd4: begin
                if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; end
                else begin e.lo = a / b; e.hi = a % b; end
            end
            default: begin e.hi = cur_hi; e.lo = cur_lo; end
        endcase
        return e;
    endfunction

    task automatic push_exp(input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.hi = h;
        e.lo = l;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
            check_val({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
            cur_hi = e.hi;
            cur_lo = e.lo;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div op, count stall cycles, optionally hold DONE with stall_in.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        exp_t e;
        int   n;
        e = model(op, a, b);
        push_exp(e.hi, e.lo);
        md_op_e  = op;
        srca_e   = a;
        srcb_e   = b;
        stall_in = (hold > 0);
        #3;
        n = 0;
        while (stall_md === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #4;
        end
        check_val({tag, "_stall_cycles"}, 64'(n), (op >= 3'd3) ? 64'd33 : 64'(MC + 1));
        for (int k = 0; k < hold; k++) begin
            check_val({tag, "_hold_busy"}, {63'd0, busy}, 64'd1);
            check_val({tag, "_hold_hi"}, {32'd0, hi}, {32'd0, cur_hi});
            check_val({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, cur_lo});
            tick();
            if (k == hold - 1) stall_in = 1'b0;
            #3;
        end
        check_val({tag, "_done_stall"}, {63'd0, stall_md}, 64'd0);
        check_val({tag, "_done_busy"}, {63'd0, busy}, 64'd1);
        tick();
        md_op_e = 3'd0;
        #3;
        sb_pop_check(tag);
        check_val({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
        tick();
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        resetn = 1'b0; md_op_e = 3'd0; srca_e = 32'd0; srcb_e = 32'd0;
        stall_in = 1'b0; flush = 1'b0;
        repeat (3) tick();
        #3;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_stall", {63'd0, stall_md}, 64'd0);
        check_val("rst_hi", {32'd0, hi}, 64'd0);
        check_val("rst_lo", {32'd0, lo}, 64'd0);
        tick();
        resetn = 1'b1;
        tick();

        run_op("mult_neg1x2", 3'd1, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("multu_neg1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_100_7", 3'd4, 32'd100, 32'd7, 0);
        run_op("div_5_0", 3'd3, 32'd5, 32'd0, 0);
        run_op("div_min_m1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // MTHI/MTLO to 0x1234, then flush a DIV at its 10th busy cycle.
        push_exp(32'h1234, 32'h1234);
        md_op_e = 3'd5; srca_e = 32'h1234; tick();
        md_op_e = 3'd6; tick();
        md_op_e = 3'd0; #3;
        sb_pop_check("mt_1234");
        tick();
        push_exp(cur_hi, cur_lo);
        md_op_e = 3'd3; srca_e = 32'd1000; srcb_e = 32'd3;
        repeat (10) tick();
        flush = 1'b1;
        #3;
        check_val("flush_pre_stall", {63'd0, stall_md}, 64'd1);
        tick();
        flush = 1'b0; md_op_e = 3'd0;
        #3;
        check_val("flush_busy", {63'd0, busy}, 64'd0);
        check_val("flush_stall", {63'd0, stall_md}, 64'd0);
        sb_pop_check("flush_div");
        tick();

        run_op("mult_after_flush", 3'd1, 32'hFFFF_FFFD, 32'd7, 0);
        run_op("divu_hold3", 3'd4, 32'd1000, 32'd9, 3);
        for (int k = 0; k < 3; k++) begin
            #3;
            check_val("no_restart_busy", {63'd0, busy}, 64'd0);
            check_val("no_restart_hi", {32'd0, hi}, {32'd0, cur_hi});
            tick();
        end

        // Flush together with a start in IDLE: no start, no stall.
        md_op_e = 3'd1; srca_e = 32'd3; srcb_e = 32'd3; flush = 1'b1;
        #3;
        check_val("flush_start_stall", {63'd0, stall_md}, 64'd0);
        tick();
        flush = 1'b0; md_op_e = 3'd0;
        #3;
        check_val("flush_start_busy", {63'd0, busy}, 64'd0);
        tick();

        // Flush together with stall_in in DONE: no commit.
        push_exp(cur_hi, cur_lo);
        md_op_e = 3'd2; srca_e = 32'd11; srcb_e = 32'd13;
        repeat (MC + 1) tick();
        stall_in = 1'b1; flush = 1'b1;
        #3;
        check_val("flush_done_busy", {63'd0, busy}, 64'd1);
        tick();
        stall_in = 1'b0; flush = 1'b0; md_op_e = 3'd0;
        #3;
        check_val("flush_done_idle", {63'd0, busy}, 64'd0);
        sb_pop_check("flush_done");
        tick();

        // MTHI held by stall_in for two cycles.
        push_exp(32'hA5A5_A5A5, cur_lo);
        md_op_e = 3'd5; srca_e = 32'hA5A5_A5A5; stall_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #3;
            check_val("mthi_stalled_hi", {32'd0, hi}, {32'd0, cur_hi});
            tick();
        end
        stall_in = 1'b0;
        #3;
        check_val("mthi_release_hi", {32'd0, hi}, {32'd0, cur_hi});
        tick();
        md_op_e = 3'd0;
        #3;
        sb_pop_check("mthi_read");
        tick();

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                  (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a DIV clears HI/LO and returns to IDLE.
        push_exp(32'd0, 32'd0);
        md_op_e = 3'd3; srca_e = 32'd77; srcb_e = 32'd5;
        repeat (6) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1; md_op_e = 3'd0;
        #3;
        check_val("rst_mid_busy", {63'd0, busy}, 64'd0);
        sb_pop_check("rst_mid_div");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
